unidade_controle_jogo: RTL
==========================

Name: unidade_controle_jogo

Overview:
Moore control unit that sequences the counter/comparator datapath (4-bit counter with zera/conta, compared against chaves; flags igual and fim). It drives the datapath control lines and consumes its status flags. It runs one round: clear the counter, wait for each player move, latch the switches, check igual, then advance the counter or finish. It reports pronto/acertou/errou and exposes its state for debug.

Parameters:
TIMEOUT_CICLOS, 1000, cycles allowed in ESPERA before a timeout. Used only when TIMEOUT_EN is defined; must be ≥2.

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
iniciar  input  1  start/restart request, level-sampled
jogada  input  1  player move button, level; an internal rising-edge detector turns it into a one-shot
igual  input  1  datapath: counter value equals latched chaves
fim  input  1  datapath: counter at terminal value (15)
zera  output  1  datapath: synchronous counter clear
conta  output  1  datapath: counter increment enable
registra  output  1  datapath: latch chaves into the comparison register
pronto  output  1  round finished
acertou  output  1  round finished, all moves correct
errou  output  1  round finished, wrong move or timeout
timeout  output  1  round ended by timeout
db_estado  output  4  current state encoding

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset asserted (reset=0), at any time including mid-round:
  - state=INICIAL, edge register=0, timeout counter=0.
  - All outputs 0; db_estado=0000.
- Edge detector:
  - jogada_d <= jogada every cycle.
  - pulso = jogada & ~jogada_d.
  - A level held high produces only one pulso, and needs release then re-press for the next.
  - pulso is ignored in every state except ESPERA.
- Outputs are Moore-decoded from the state register and valid in the same cycle as the state.
- States (encoding), output, transitions:
  - INICIAL (0000): all outputs 0. iniciar=1 -> PREPARA.
  - PREPARA (0001): zera=1. Always -> ESPERA.
  - ESPERA (0010): outputs 0. pulso=1 -> REGISTRA. Timeout expiry -> FIM_TIMEOUT (macro only).
  - REGISTRA (0011): registra=1. -> COMPARA.
  - COMPARA (0100): outputs 0. Priority: igual=0 -> FIM_ERROU; else fim=1 -> FIM_ACERTOU; else -> PROXIMO.
  - PROXIMO (0101): conta=1. -> ESPERA.
  - FIM_ACERTOU (1010): pronto=1, acertou=1. iniciar=1 -> PREPARA, else hold.
  - FIM_ERROU (1110): pronto=1, errou=1. iniciar=1 -> PREPARA, else hold.
  - FIM_TIMEOUT (1111): pronto=1, errou=1, timeout=1. iniciar=1 -> PREPARA, else hold.
  - Unused encodings -> INICIAL.
- Latency:
  - iniciar sampled high at edge n: zera high in cycle n+1, ESPERA from n+2.
  - jogada first sampled high at edge k: registra high in cycle k+1, COMPARA decided in k+2.
- zera, registra and conta are each exactly one cycle wide per visit.
- conta is never asserted on the final (fim=1) or erroneous move.
- iniciar is ignored outside INICIAL and the FIM states.

Optional Feature:
TIMEOUT_EN
- Defined:
  - An internal counter of width $clog2(TIMEOUT_CICLOS) is cleared in every state except ESPERA and increments each ESPERA cycle.
  - When it equals TIMEOUT_CICLOS-1 and pulso=0, the next state is FIM_TIMEOUT.
  - pulso in the expiry cycle wins: go to REGISTRA.
  - The counter restarts at 0 on every entry into ESPERA.
- Undefined: no counter, FIM_TIMEOUT is unreachable, and the timeout port is tied 0.

Test Plan:
- reset=0 asserted mid-cycle while in PROXIMO -> db_estado=0000 and all outputs 0 immediately, before the next clock edge; after release, the FSM stays in INICIAL with iniciar=0.
- iniciar=1 for one cycle -> zera=1 for exactly one cycle (db_estado 0001), then 0010. jogada pulse with igual=1, fim=0 -> registra one cycle (0011), then 0100, conta one cycle (0101), then back to 0010.
- 16 jogada pulses with igual=1 and fim=1 only at the 16th COMPARA -> conta seen 15 times; db_estado=1010, pronto=1, acertou=1, held until iniciar.
- igual=0 at the 3rd COMPARA -> db_estado=1110, pronto=1, errou=1. Then iniciar=1 -> zera=1 and the next round proceeds normally.
- jogada held high for 20 cycles in ESPERA -> exactly one registra pulse; FSM waits in 0010 until release and re-press.
- TIMEOUT_EN defined, TIMEOUT_CICLOS=8:
  - No jogada for 8 ESPERA cycles -> db_estado=1111, timeout=1, errou=1, acertou=0.
  - A pulse in the 8th cycle -> REGISTRA instead.
  - Without the macro: 100 idle cycles remain in 0010 with timeout=0.

Source files
------------

// File: rtl/unidade_controle_jogo_if.sv
// Control/status bundle between the game control unit and its counter/comparator datapath.
// The master side is the control unit; the slave side is the datapath and front panel.
interface unidade_controle_jogo_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim;
  logic       zera;
  logic       conta;
  logic       registra;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar,
    input  jogada,
    input  igual,
    input  fim,
    output zera,
    output conta,
    output registra,
    output pronto,
    output acertou,
    output errou,
    output timeout,
    output db_estado
  );

  modport slave (
    output iniciar,
    output jogada,
    output igual,
    output fim,
    input  zera,
    input  conta,
    input  registra,
    input  pronto,
    input  acertou,
    input  errou,
    input  timeout,
    input  db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for one game round: clear the counter, wait for each move, latch the
// switches, check the comparison and either advance or finish.
// Optional feature: define TIMEOUT_EN to abort a round after TIMEOUT_CICLOS idle cycles in ESPERA.
module unidade_controle_jogo #(
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  unidade_controle_jogo_if.master bus
);

  localparam logic [3:0] StInicial    = 4'b0000;
  localparam logic [3:0] StPrepara    = 4'b0001;
  localparam logic [3:0] StEspera     = 4'b0010;
  localparam logic [3:0] StRegistra   = 4'b0011;
  localparam logic [3:0] StCompara    = 4'b0100;
  localparam logic [3:0] StProximo    = 4'b0101;
  localparam logic [3:0] StFimAcertou = 4'b1010;
  localparam logic [3:0] StFimErrou   = 4'b1110;
  localparam logic [3:0] StFimTimeout = 4'b1111;

  logic [3:0] estado_q, estado_d;
  logic       jogada_q, jogada_d;
  logic       pulso;
  logic       expirou;

  // One-shot on the rising edge of the move button.
  assign jogada_d = bus.jogada;
  assign pulso    = bus.jogada & ~jogada_q;

`ifdef TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;

  // Idle counter: runs only while waiting for a move, restarts on every entry into ESPERA.
  always_comb begin
    tcnt_d = '0;
    if (estado_q == StEspera) begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign expirou = (estado_q == StEspera) && (tcnt_q == TLast);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CICLOS >= 2);
  assign expirou = 1'b0;
`endif

  // State and edge-detector registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
      jogada_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      jogada_q <= jogada_d;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d = StInicial;
    case (estado_q)
      StInicial:  estado_d = bus.iniciar ? StPrepara : StInicial;
      StPrepara:  estado_d = StEspera;
      StEspera: begin
        // A move in the expiry cycle takes precedence over the timeout.
        if (pulso) begin
          estado_d = StRegistra;
        end else if (expirou) begin
          estado_d = StFimTimeout;
        end else begin
          estado_d = StEspera;
        end
      end
      StRegistra: estado_d = StCompara;
      StCompara: begin
        if (!bus.igual) begin
          estado_d = StFimErrou;
        end else if (bus.fim) begin
          estado_d = StFimAcertou;
        end else begin
          estado_d = StProximo;
        end
      end
      StProximo:    estado_d = StEspera;
      StFimAcertou: estado_d = bus.iniciar ? StPrepara : StFimAcertou;
      StFimErrou:   estado_d = bus.iniciar ? StPrepara : StFimErrou;
      StFimTimeout: estado_d = bus.iniciar ? StPrepara : StFimTimeout;
      default:      estado_d = StInicial;
    endcase
  end

  // Moore output decode.
  always_comb begin
    bus.zera     = 1'b0;
    bus.conta    = 1'b0;
    bus.registra = 1'b0;
    bus.pronto   = 1'b0;
    bus.acertou  = 1'b0;
    bus.errou    = 1'b0;
    case (estado_q)
      StPrepara:  bus.zera     = 1'b1;
      StRegistra: bus.registra = 1'b1;
      StProximo:  bus.conta    = 1'b1;
      StFimAcertou: begin
        bus.pronto  = 1'b1;
        bus.acertou = 1'b1;
      end
      StFimErrou, StFimTimeout: begin
        bus.pronto = 1'b1;
        bus.errou  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef TIMEOUT_EN
  assign bus.timeout = (estado_q == StFimTimeout);
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.db_estado = estado_q;

endmodule
